mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the 8-bit multicycle CPU. Answers the control unit's mem_read/mem_write requests against a 32x8 unified program/data RAM.
- Owns the boot loader that fills RAM from an external byte stream while the CPU is held off.
- Maps one I/O address to a small output FIFO, so program STOREs can emit bytes to an external consumer that applies backpressure.

Parameters:
- IO_ADDR, 5'd30, address decoded as the output-port/status location instead of RAM in RUN.
- OUT_DEPTH, 4, output FIFO depth in entries (power of two, 2..8).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read enable.
- mem_write  in  1  CPU write enable.
- mem_addr  in  5  CPU address (PC or IR[4:0], muxed upstream).
- mem_wdata  in  8  CPU store data (register R0).
- mem_rdata  out  8  read data, combinational from mem_addr.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks the final loader byte; qualified by ld_valid.
- ld_ready  out  1  loader can accept.
- cpu_run  out  1  registered; high releases the CPU (drives its reset release).
- out_valid  out  1  output FIFO non-empty.
- out_data  out  8  FIFO head byte (show-ahead).
- out_ready  in  1  consumer accepts the head when out_valid is high.
- out_overflow  out  1  sticky: a store to IO_ADDR was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n low, async):
  - State = LOAD; load pointer = 0.
  - cpu_run = 0, ld_ready = 1.
  - FIFO empty; out_valid = 0, out_data = 0, out_overflow = 0.
  - RAM contents are not cleared.
- States: LOAD, RUN. Reset mid-operation from either state returns to LOAD; the FIFO is flushed and pointers are zeroed.
- LOAD:
  - ld_ready = 1. Each cycle with ld_valid & ld_ready writes ram[ptr] = ld_data and increments ptr.
  - Transition to RUN on the posedge that accepts a byte with ld_last = 1, or on acceptance at ptr = 31, whichever comes first.
  - cpu_run rises the cycle after that acceptance.
  - CPU-side mem_read/mem_write are ignored; mem_rdata = 8'h00.
  - Locations not loaded keep their previous contents.
- RUN:
  - ld_ready = 0; ld_valid is ignored.
  - Stays in RUN until reset; there is no return to LOAD.
- RUN reads (combinational, zero latency; required because the CPU captures IR in the FETCH cycle itself):
  - mem_addr != IO_ADDR: mem_rdata = ram[mem_addr].
  - mem_addr == IO_ADDR: mem_rdata = {5'b0, out_overflow, full, empty}.
  - mem_rdata is driven even when mem_read = 0 (value unspecified-but-stable; the bench checks only when mem_read = 1).
- RUN writes (posedge, mem_write = 1):
  - mem_addr != IO_ADDR: ram[mem_addr] = mem_wdata.
  - mem_addr == IO_ADDR: push mem_wdata into the FIFO. Never written to RAM.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and out_overflow is set.
  - mem_read and mem_write high together: the write takes effect; mem_rdata shows the old value that cycle.
- Output FIFO:
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop when full: both occur; no overflow.
  - Simultaneous push and pop when empty: the push lands and out_valid rises next cycle; the pop is a no-op since out_valid = 0.
  - out_data = head entry when non-empty, 8'h00 when empty.
  - Occupancy counter is log2(OUT_DEPTH)+1 bits; read/write pointers wrap modulo OUT_DEPTH.
- out_overflow clears only on reset.
- Note: fetching from IO_ADDR returns the status byte as an instruction; this is a program error, not handled here.

Test Plan:
- Reset, stream 32 bytes 8'h00..8'h1F with ld_last low -> ld_ready drops after byte 31; cpu_run = 1 the next cycle; RUN reads ram[5] = 8'h05, ram[30] read returns status 8'h01 (empty).
- Load 3 bytes, ld_last on 3rd -> cpu_run high one cycle later; ld_valid afterwards does not modify ram[3].
- RUN: mem_write addr 7 data 8'hA5, then mem_read addr 7 -> mem_rdata = 8'hA5 combinationally in the read cycle.
- RUN, out_ready = 0: 5 stores to IO_ADDR (8'h10..8'h14) -> entries 10..13 held, status = 8'h02 then 8'h06 after the 5th; raise out_ready -> 10,11,12,13 drained in order, then out_valid = 0.
- FIFO full, store to IO_ADDR with out_ready = 1 the same cycle -> no overflow; next head = 8'h11, tail = new byte.
- Pulse reset_n low mid-LOAD (ptr = 9) and again in RUN with 2 FIFO entries -> LOAD, ptr = 0, cpu_run = 0, out_valid = 0, out_overflow = 0 immediately (async).

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit multicycle CPU: 32x8 unified RAM, boot loader,
// and a memory-mapped output FIFO with a status byte at IO_ADDR.
module mem_responder #(
  parameter logic [4:0]  IO_ADDR   = 5'd30,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [4:0] mem_addr,
  input  logic [7:0] mem_wdata,
  output logic [7:0] mem_rdata,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_run,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       out_overflow
);

  localparam int unsigned AW       = $clog2(OUT_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t        state, state_nxt;
  logic [4:0]    ld_ptr;
  logic [7:0]    ram [32];
  logic [7:0]    fifo [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ld_accept, io_hit, push_req, push, pop, full, empty;

  // Reads are combinational regardless of mem_read, so the enable is not needed.
  logic unused_mem_read;
  assign unused_mem_read = mem_read;

  always_comb begin
    ld_accept = (state == LOAD) && ld_valid;
    io_hit    = (mem_addr == IO_ADDR);
    empty     = (count == '0);
    full      = (count == FULL_CNT);
    pop       = !empty && out_ready;
    push_req  = (state == RUN) && mem_write && io_hit;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push      = push_req && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD;
      cpu_run <= 1'b0;
      ld_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      cpu_run <= (state_nxt == RUN);
      if (ld_accept) ld_ptr <= ld_ptr + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ld_accept && (ld_last || ld_ptr == 5'd31)) state_nxt = RUN;
  end

  always_comb begin
    ld_ready  = (state == LOAD);
    mem_rdata = '0;
    if (state == RUN) begin
      if (io_hit) mem_rdata = {5'b0, out_overflow, full, empty};
      else        mem_rdata = ram[mem_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (ld_accept)
      ram[ld_ptr] <= ld_data;
    else if ((state == RUN) && mem_write && !io_hit)
      ram[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) out_overflow <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : fifo[rd_ptr];

endmodule
